// File: rtl/digit_serial_add3_pkg.sv
// Shared definitions for the digit-serial 3-bit adder sequencer.
package digit_serial_add3_pkg;

  // Width of one digit handled by the adder slice per clock.
  localparam int DIGIT_W = 3;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : digit_serial_add3_pkg

// File: rtl/digit_serial_add3_slice.sv
// Three-bit ripple-carry slice built from full-adder cells.
module add3_slice
  import digit_serial_add3_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] s,
  output logic [DIGIT_W-1:0] carry
);

  // Ripple the carry through each full-adder cell, low bit first.
  always_comb begin
    logic c;
    c     = c_in;
    s     = '0;
    carry = '0;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c;
      carry[i] = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      c        = carry[i];
    end
  end

endmodule : add3_slice

// File: rtl/digit_serial_add3.sv
// Digit-serial adder: feeds one 3-bit slice per clock and assembles a
// WIDTH-bit sum with valid/ready handshakes on both sides.
module digit_serial_add3
  import digit_serial_add3_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               cy_q, cy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;

  logic [DIGIT_W-1:0] slice_s;
  logic [DIGIT_W-1:0] slice_carry;
  logic [DIGIT_W-2:0] carry_unused;
  logic [WIDTH-1:0]   sum_ins;

  add3_slice u_slice (
    .a     (a_sh_q[DIGIT_W-1:0]),
    .b     (b_sh_q[DIGIT_W-1:0]),
    .c_in  (cy_q),
    .s     (slice_s),
    .carry (slice_carry)
  );

  // Only the top carry of the slice travels to the next digit.
  assign carry_unused = slice_carry[DIGIT_W-2:0];

  // New digit enters the sum shifter at the top; a single-digit build has no older bits to keep.
  generate
    if (DIGITS == 1) begin : g_one_digit
      assign sum_ins = slice_s;
    end else begin : g_multi_digit
      assign sum_ins = {slice_s, sum_sh_q[WIDTH-1:DIGIT_W]};
    end
  endgenerate

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = a;
          b_sh_d  = b;
          cy_d    = c_in;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cy_d     = slice_carry[DIGIT_W-1];
        sum_sh_d = sum_ins;
        a_sh_d   = a_sh_q >> DIGIT_W;
        b_sh_d   = b_sh_q >> DIGIT_W;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  // State, datapath and registered handshake outputs; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_sh_q;
  assign c_out     = cy_q;

endmodule : digit_serial_add3

// File: tb/tb_digit_serial_add3.sv
// Directed bench for digit_serial_add3: a 12-bit and a 3-bit instance.
module tb_digit_serial_add3;

  logic        clk;
  logic        rst_n;

  logic        inValid, inReady, outValid, outReady, cIn, cOut, busy;
  logic [11:0] aIn, bIn, sum;

  logic        inValid3, inReady3, outValid3, outReady3, cIn3, cOut3, busy3;
  logic [2:0]  aIn3, bIn3, sum3;

  int          testsRun;
  int          testsFailed;

  digit_serial_add3 #(.WIDTH(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (aIn),
    .b         (bIn),
    .c_in      (cIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sum),
    .c_out     (cOut),
    .busy      (busy)
  );

  digit_serial_add3 #(.WIDTH(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid3),
    .in_ready  (inReady3),
    .a         (aIn3),
    .b         (bIn3),
    .c_in      (cIn3),
    .out_valid (outValid3),
    .out_ready (outReady3),
    .sum       (sum3),
    .c_out     (cOut3),
    .busy      (busy3)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one operand pair to the 12-bit instance, wait for the result, check it and accept it.
  // Latency counts edges from the accept edge inclusive, so DIGITS+1 = 5 is expected.
  task automatic applyStimulus(input string tag, input logic [11:0] a, input logic [11:0] b,
                               input logic c, input logic [11:0] expSum, input logic expCout);
    int cycles;
    checkOutput({tag, "_in_ready"}, 32'(inReady), 32'd1);
    aIn     = a;
    bIn     = b;
    cIn     = c;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    cycles  = 1;
    while (!outValid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd5);
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, "_c_out"}, 32'(cOut), 32'(expCout));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(outValid), 32'd0);
    checkOutput({tag, "_sum_hold"}, 32'(sum), 32'(expSum));
  endtask

  initial begin
    int cycles;
    int seenValid;
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    aIn         = '0;
    bIn         = '0;
    cIn         = 1'b0;
    inValid3    = 1'b0;
    outReady3   = 1'b0;
    aIn3        = '0;
    bIn3        = '0;
    cIn3        = 1'b0;

    // Reset and idle state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_c_out", 32'(cOut), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // Main function over several operand patterns.
    applyStimulus("fff_001", 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1);
    applyStimulus("555_aaa", 12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1);
    applyStimulus("123_456", 12'h123, 12'h456, 1'b0, 12'h579, 1'b0);

    // Back-pressure: result held for three cycles, stray in_valid ignored.
    aIn = 12'h800; bIn = 12'h900; cIn = 1'b1; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    cycles  = 1;
    while (!outValid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("bp_latency", 32'(cycles), 32'd5);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        aIn = 12'h777; bIn = 12'h777; cIn = 1'b0; inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      checkOutput($sformatf("bp_valid_%0d", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("bp_sum_%0d", i), 32'(sum), 32'h101);
      checkOutput($sformatf("bp_c_out_%0d", i), 32'(cOut), 32'd1);
      checkOutput($sformatf("bp_in_ready_%0d", i), 32'(inReady), 32'd0);
      @(negedge clk);
    end
    inValid = 1'b0;
    checkOutput("bp_still_done", 32'(outValid), 32'd1);
    checkOutput("bp_sum_after_pulse", 32'(sum), 32'h101);

    // Output handshake together with in_valid: must not accept that cycle.
    aIn = 12'h777; bIn = 12'h777; inValid = 1'b1; outReady = 1'b1;
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("hs_in_busy", 32'(busy), 32'd0);
    checkOutput("hs_in_ready", 32'(inReady), 32'd1);
    checkOutput("hs_valid", 32'(outValid), 32'd0);
    checkOutput("hs_sum_hold", 32'(sum), 32'h101);
    checkOutput("hs_c_out_hold", 32'(cOut), 32'd1);

    // Reset during the second RUN cycle discards the operation.
    aIn = 12'hABC; bIn = 12'h111; cIn = 1'b0; inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("mid_rst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    seenValid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid) seenValid++;
    end
    checkOutput("mid_no_valid", 32'(seenValid), 32'd0);
    checkOutput("mid_idle", 32'(inReady), 32'd1);
    applyStimulus("0ff_001", 12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0);

    // Single-digit instance: RUN lasts one cycle.
    checkOutput("w3_in_ready", 32'(inReady3), 32'd1);
    aIn3 = 3'b111; bIn3 = 3'b001; cIn3 = 1'b1; inValid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid3 = 1'b0;
    cycles   = 1;
    while (!outValid3 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("w3_latency", 32'(cycles), 32'd2);
    checkOutput("w3_sum", 32'(sum3), 32'd1);
    checkOutput("w3_c_out", 32'(cOut3), 32'd1);
    outReady3 = 1'b1;
    @(negedge clk);
    outReady3 = 1'b0;
    checkOutput("w3_valid_drop", 32'(outValid3), 32'd0);
    checkOutput("w3_in_ready_after", 32'(inReady3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_digit_serial_add3
